// File: rtl/vga_pkg.sv
// Shared VGA display constants and the frame-reader state encoding.
package vga_pkg;

  localparam int unsigned VIDEO_WIDTH  = 640;
  localparam int unsigned VIDEO_HEIGHT = 480;
  localparam int unsigned PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int unsigned ADDR_WIDTH   = 20;
  localparam int unsigned X_WIDTH      = 10;
  localparam int unsigned Y_WIDTH      = 9;
  localparam int unsigned READ_LATENCY = 1;
  localparam int unsigned PIXEL_DIV    = 2;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SCAN       = 2'd1,
    DRAIN      = 2'd2,
    BLANK      = 2'd3
  } reader_state_e;

endpackage

// File: rtl/sync_delay_line.sv
// N-deep, W-wide register chain that advances on en_i; every stage resets to RST_VAL.
module sync_delay_line #(
  parameter int unsigned   N       = 2,
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  localparam int unsigned CW = N * W;

  logic [CW-1:0] chain_q;

  // Oldest sample sits in the top W bits; new samples enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {N{RST_VAL}};
    end else if (en_i) begin
      chain_q <= (chain_q << W) | CW'(d_i);
    end
  end

  assign q_o = chain_q[CW-1 -: W];

endmodule

// File: rtl/boid_frame_reader.sv
// Display-RAM read side: raster-to-address counter, pixel/sync re-alignment and end-of-frame pulse.
// Optional feature macro BOID_PIXEL_COUNT_EN adds boid_pix_count (set pixels seen in the last frame).
module boid_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned FRAME_LINES = VIDEO_HEIGHT
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pixel_en,
  input  logic [X_WIDTH-1:0]    x_in,
  input  logic [Y_WIDTH-1:0]    y_in,
  input  logic                  active_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_data,
  output logic                  pixel_on,
  output logic                  active_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  screen_end,
`ifdef BOID_PIXEL_COUNT_EN
  output logic [ADDR_WIDTH-1:0] boid_pix_count,
`endif
  output logic                  addr_err
);

  localparam logic [X_WIDTH-1:0] LAST_X = X_WIDTH'(VIDEO_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] LAST_Y = Y_WIDTH'(FRAME_LINES - 1);

  reader_state_e         state_q;
  logic [ADDR_WIDTH-1:0] lin_cnt_q;
  logic                  rd_vld_q;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic                  rd_fire;
  logic                  enter_scan;
  logic                  frame_started;
  logic                  last_px;
  logic                  stage2_bit;
  logic [2:0]            sync_q;

  // x + 640*y as x + 512*y + 128*y
  assign exp_addr      = ADDR_WIDTH'(x_in) + (ADDR_WIDTH'(y_in) << 9) + (ADDR_WIDTH'(y_in) << 7);
  assign rd_fire       = pixel_en & vsync_in & active_in & (state_q == SCAN);
  assign enter_scan    = pixel_en & ~vsync_in & ((state_q == WAIT_FRAME) | (state_q == BLANK));
  assign frame_started = (lin_cnt_q != '0);
  assign last_px       = (x_in == LAST_X) && (y_in == LAST_Y);
  assign stage2_bit    = read_data & rd_vld_q;

  // A multi-tick vsync pulse keeps the counter at zero, so vsync in SCAN only
  // counts as a truncated frame once at least one read has been issued.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= WAIT_FRAME;
      lin_cnt_q  <= '0;
      rd_vld_q   <= 1'b0;
      read_addr  <= '0;
      pixel_on   <= 1'b0;
      screen_end <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      screen_end <= 1'b0;
      if (pixel_en) begin
        pixel_on <= stage2_bit;
        rd_vld_q <= rd_fire;

        if (!vsync_in) begin
          lin_cnt_q <= '0;
        end else if (rd_fire) begin
          read_addr <= lin_cnt_q;
          if (lin_cnt_q == exp_addr) begin
            lin_cnt_q <= lin_cnt_q + ADDR_WIDTH'(1);
          end else begin
            lin_cnt_q <= exp_addr + ADDR_WIDTH'(1);
            addr_err  <= 1'b1;
          end
        end

        case (state_q)
          WAIT_FRAME, BLANK: begin
            if (enter_scan) state_q <= SCAN;
          end
          SCAN: begin
            if (!vsync_in) begin
              if (frame_started) begin
                state_q  <= BLANK;
                addr_err <= 1'b1;
              end
            end else if (rd_fire && last_px) begin
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            screen_end <= 1'b1;
            state_q    <= BLANK;
          end
          default: state_q <= WAIT_FRAME;
        endcase
      end
    end
  end

  sync_delay_line #(
    .N       (2),
    .W       (3),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk   (clock),
    .rst_n (resetn),
    .en_i  (pixel_en),
    .d_i   ({hsync_in, vsync_in, active_in}),
    .q_o   (sync_q)
  );

  assign {hsync_out, vsync_out, active_out} = sync_q;

`ifdef BOID_PIXEL_COUNT_EN
  logic [ADDR_WIDTH-1:0] pix_cnt_q;
  logic [ADDR_WIDTH-1:0] pix_cnt_d;

  assign pix_cnt_d = pix_cnt_q + ADDR_WIDTH'(stage2_bit);

  // Snapshot includes the last pixel, which lands on the DRAIN tick.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_cnt_q      <= '0;
      boid_pix_count <= '0;
    end else if (pixel_en) begin
      pix_cnt_q <= enter_scan ? '0 : pix_cnt_d;
      if (state_q == DRAIN) boid_pix_count <= pix_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_boid_frame_reader.sv
// Bench for boid_frame_reader on a shortened frame (640 x 11 lines) with a randomly filled RAM model.
module tb_boid_frame_reader;
  import vga_pkg::*;

  localparam int H    = 11;
  localparam int W    = 640;
  localparam int NPIX = W * H;

  logic                  clock;
  logic                  resetn;
  logic                  pixel_en;
  logic [9:0]            x_in;
  logic [8:0]            y_in;
  logic                  active_in;
  logic                  hsync_in;
  logic                  vsync_in;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_data;
  logic                  pixel_on;
  logic                  active_out;
  logic                  hsync_out;
  logic                  vsync_out;
  logic                  screen_end;
  logic                  addr_err;
`ifdef BOID_PIXEL_COUNT_EN
  logic [ADDR_WIDTH-1:0] boid_pix_count;
`endif

  int checks = 0;
  int errors = 0;
  int se_pulses = 0;
  int on_hits = 0;

  bit ram [NPIX];

  // reference model state
  bit       m_read, m_drain, m_err, m_prv_rd, m_pix, m_se;
  int       m_cnt, m_addr, m_prv_addr, m_pc, m_bpc;
  bit [2:0] m_d0, m_out;

  boid_frame_reader #(.FRAME_LINES(H)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pixel_en   (pixel_en),
    .x_in       (x_in),
    .y_in       (y_in),
    .active_in  (active_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .pixel_on   (pixel_on),
    .active_out (active_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .screen_end (screen_end),
`ifdef BOID_PIXEL_COUNT_EN
    .boid_pix_count (boid_pix_count),
`endif
    .addr_err   (addr_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial read_data = 1'b0;
  always @(posedge clock)
    read_data <= (int'(read_addr) < NPIX) ? ram[int'(read_addr)] : 1'b0;

  always @(posedge clock)
    if (screen_end === 1'b1) se_pulses++;

  task automatic load_ram(input bit rnd);
    for (int i = 0; i < NPIX; i++) ram[i] = rnd ? ($urandom_range(15) == 0) : 1'b0;
    ram[0] = 1'b1;
    ram[10 * W + 10] = 1'b1;
    ram[NPIX - 1] = 1'b1;
  endtask

  function automatic int ram_ones();
    int n = 0;
    for (int i = 0; i < NPIX; i++) n += int'(ram[i]);
    return n;
  endfunction

  task automatic model_reset();
    m_read = 0; m_drain = 0; m_err = 0; m_prv_rd = 0; m_pix = 0; m_se = 0;
    m_cnt = 0; m_addr = 0; m_prv_addr = 0; m_pc = 0; m_bpc = 0;
    m_d0 = 3'b110; m_out = 3'b110;
  endtask

  // One pixel tick of the reader, computed from the frame rules directly.
  task automatic model_tick(input int x, input int y, input bit a, input bit h, input bit v);
    int ea;
    m_se    = m_drain;
    m_drain = 0;
    m_pix   = m_prv_rd ? ram[m_prv_addr] : 1'b0;
    m_pc   += int'(m_pix);
    if (m_se) m_bpc = m_pc;
    m_prv_rd = 0;
    if (!v) begin
      if (m_read && m_cnt != 0) begin
        m_err  = 1;
        m_read = 0;
      end else if (!m_read) begin
        m_read = 1;
        m_pc   = 0;
      end
      m_cnt = 0;
    end else if (m_read && a) begin
      ea         = x + W * y;
      m_addr     = m_cnt;
      m_prv_rd   = 1;
      m_prv_addr = m_cnt;
      if (m_cnt != ea) begin
        m_err = 1;
        m_cnt = ea + 1;
      end else begin
        m_cnt++;
      end
      if (x == W - 1 && y == H - 1) begin
        m_read  = 0;
        m_drain = 1;
      end
    end
    m_out = m_d0;
    m_d0  = {h, v, a};
  endtask

  function automatic logic [25:0] exp_vec();
    return {ADDR_WIDTH'(m_addr), m_pix, m_out[0], m_out[2], m_out[1], m_se, m_err};
  endfunction

  function automatic logic [25:0] obs_vec();
    return {read_addr, pixel_on, active_out, hsync_out, vsync_out, screen_end, addr_err};
  endfunction

  // Idle clock, then one pixel_en clock; returns 1 ns after the tick edge.
  task automatic drive_tick(input int x, input int y, input bit a, input bit h, input bit v);
    @(negedge clock);
    pixel_en = 1'b0;
    @(negedge clock);
    x_in = 10'(x); y_in = 9'(y);
    active_in = a; hsync_in = h; vsync_in = v;
    pixel_en = 1'b1;
    model_tick(x, y, a, h, v);
    @(posedge clock);
    #1;
  endtask

  task automatic run_line(input int y, input int start_x, input int stop_x,
                          input int skip_x, input int skip_n);
    int nb;
    for (int x = start_x; x < W; x++) begin
      if (x == stop_x) return;
      if (x >= skip_x && x < skip_x + skip_n) continue;
      drive_tick(x, y, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pixel x=%0d y=%0d: got %h, want %h", x, y, obs_vec(), exp_vec());
      end
      if (pixel_on === 1'b1) on_hits++;
    end
    nb = $urandom_range(4, 2);
    for (int b = 0; b < nb; b++) begin
      drive_tick(W + b, y, 1'b0, (b == 1) ? 1'b0 : 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hblank b=%0d y=%0d: got %h, want %h", b, y, obs_vec(), exp_vec());
      end
      if (pixel_on === 1'b1) on_hits++;
    end
  endtask

  task automatic run_vblank();
    for (int i = 0; i < 6; i++) begin
      drive_tick(W, H, 1'b0, 1'b1, (i >= 1 && i <= 3) ? 1'b0 : 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL vblank i=%0d: got %h, want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; pixel_en = 1'b0;
    x_in = '0; y_in = '0; active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (read_addr !== '0)     begin errors++; $display("FAIL reset read_addr: got %0d want 0", read_addr); end
    checks++; if (pixel_on !== 1'b0)    begin errors++; $display("FAIL reset pixel_on: got %b want 0", pixel_on); end
    checks++; if (active_out !== 1'b0)  begin errors++; $display("FAIL reset active_out: got %b want 0", active_out); end
    checks++; if (hsync_out !== 1'b1)   begin errors++; $display("FAIL reset hsync_out: got %b want 1", hsync_out); end
    checks++; if (vsync_out !== 1'b1)   begin errors++; $display("FAIL reset vsync_out: got %b want 1", vsync_out); end
    checks++; if (screen_end !== 1'b0)  begin errors++; $display("FAIL reset screen_end: got %b want 0", screen_end); end
    checks++; if (addr_err !== 1'b0)    begin errors++; $display("FAIL reset addr_err: got %b want 0", addr_err); end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_full_frame();
    int se0;
    load_ram(1'b1);
    on_hits = 0;
    se0 = se_pulses;
    run_vblank();
    for (int y = 0; y < H; y++) run_line(y, 0, W, W, 0);
    repeat (2) @(posedge clock);
    checks++; if (se_pulses !== se0 + 1) begin errors++; $display("FAIL frame screen_end clocks: got %0d want 1", se_pulses - se0); end
    checks++; if (on_hits !== ram_ones()) begin errors++; $display("FAIL frame pixel_on count: got %0d want %0d", on_hits, ram_ones()); end
    checks++; if (read_addr !== ADDR_WIDTH'(NPIX - 1)) begin errors++; $display("FAIL frame last read_addr: got %0d want %0d", read_addr, NPIX - 1); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL frame addr_err: got %b want 0", addr_err); end
  endtask

  task automatic test_addr_skip();
    load_ram(1'b1);
    run_vblank();
    for (int y = 0; y < 3; y++) run_line(y, 0, W, W, 0);
    run_line(3, 0, 106, 100, 5);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL skip addr_err: got %b want 1", addr_err); end
    run_line(3, 106, 107, W, 0);
    checks++; if (read_addr !== ADDR_WIDTH'(3 * W + 106)) begin errors++; $display("FAIL skip resync read_addr: got %0d want %0d", read_addr, 3 * W + 106); end
    run_line(3, 107, W, W, 0);
    checks++; if (read_addr !== ADDR_WIDTH'(3 * W + 639)) begin errors++; $display("FAIL skip row end read_addr: got %0d want %0d", read_addr, 3 * W + 639); end
    run_line(4, 0, 300, W, 0);
  endtask

  task automatic test_reset_midframe();
    #2;
    resetn = 1'b0;
    pixel_en = 1'b0;
    #1;
    model_reset();
    checks++; if (read_addr !== '0)    begin errors++; $display("FAIL midreset read_addr: got %0d want 0", read_addr); end
    checks++; if (pixel_on !== 1'b0)   begin errors++; $display("FAIL midreset pixel_on: got %b want 0", pixel_on); end
    checks++; if (active_out !== 1'b0) begin errors++; $display("FAIL midreset active_out: got %b want 0", active_out); end
    checks++; if (hsync_out !== 1'b1)  begin errors++; $display("FAIL midreset hsync_out: got %b want 1", hsync_out); end
    checks++; if (addr_err !== 1'b0)   begin errors++; $display("FAIL midreset addr_err: got %b want 0", addr_err); end
    @(negedge clock);
    resetn = 1'b1;
    run_line(4, 300, W, W, 0);
    checks++; if (read_addr !== '0) begin errors++; $display("FAIL wait_frame read_addr: got %0d want 0", read_addr); end
  endtask

  task automatic test_truncated();
    int se0;
    run_vblank();
    run_line(0, 0, 2, W, 0);
    checks++; if (read_addr !== ADDR_WIDTH'(1)) begin errors++; $display("FAIL post-reset first reads: got %0d want 1", read_addr); end
    run_line(0, 2, W, W, 0);
    for (int y = 1; y < 5; y++) run_line(y, 0, W, W, 0);
    se0 = se_pulses;
    run_vblank();
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL truncate addr_err: got %b want 1", addr_err); end
    checks++; if (se_pulses !== se0) begin errors++; $display("FAIL truncate screen_end clocks: got %0d want 0", se_pulses - se0); end
  endtask

  task automatic test_recovery_frame();
    int se0;
    load_ram(1'b0);
    on_hits = 0;
    se0 = se_pulses;
    run_line(0, 0, 2, W, 0);
    checks++; if (read_addr !== ADDR_WIDTH'(1)) begin errors++; $display("FAIL recovery first reads: got %0d want 1", read_addr); end
    run_line(0, 2, W, W, 0);
    for (int y = 1; y < H; y++) run_line(y, 0, W, W, 0);
    repeat (2) @(posedge clock);
    checks++; if (se_pulses !== se0 + 1) begin errors++; $display("FAIL recovery screen_end clocks: got %0d want 1", se_pulses - se0); end
    checks++; if (on_hits !== 3) begin errors++; $display("FAIL recovery pixel_on count: got %0d want 3", on_hits); end
`ifdef BOID_PIXEL_COUNT_EN
    checks++; if (boid_pix_count !== ADDR_WIDTH'(3)) begin errors++; $display("FAIL boid_pix_count: got %0d want 3", boid_pix_count); end
    checks++; if (boid_pix_count !== ADDR_WIDTH'(m_bpc)) begin errors++; $display("FAIL boid_pix_count model: got %0d want %0d", boid_pix_count, m_bpc); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_addr_skip();
    test_reset_midframe();
    test_truncated();
    test_recovery_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
